bcd_conv_arbiter: RTL and testbench
===================================

# bcd_conv_arbiter

Shares one binary-to-BCD converter among N requesters, such as cores or debug taps that want a value shown on the seven-segment display path. Requesters are served in round-robin order. For each grant the block launches one conversion through the converter's active-low start/done handshake, captures the 8-digit packed BCD result, and returns it with the winner's ID. It sits between the requesters and the converter. Downstream display logic consumes `resp_bcd`.

## Interface
- `N`, default 4: number of requesters (2..8).
- `IDW`, default 2: ID width, equal to ceil(log2 N).
- `clk` in, 1: system clock. All state updates on the rising edge.
- `rst` in, 1: reset, asynchronous, active-low.
- `req` in, N: level request, one bit per requester.
- `req_value` in, N*26: packed binary values; requester i owns bits [26i+25:26i].
- `ack` out, N: one-cycle pulse to the served requester.
- `resp_valid` out, 1: one-cycle pulse; `resp_id`, `resp_bcd` and `resp_err` are valid in that cycle.
- `resp_id` out, IDW: ID of the served requester.
- `resp_bcd` out, 32: digit7..digit0, packed 4 bits per digit, digit7 in MSBs. Holds until the next response.
- `resp_err` out, 1: conversion timed out (see Configuration).
- `busy` out, 1: high in every state except IDLE.
- `conv_value` out, 26: registered operand driven to the converter.
- `conv_start_n` out, 1: active-low start strobe to the converter.
- `conv_ready` in, 1: converter idle.
- `conv_done_n` in, 1: active-low done from the converter; digits are valid in the same cycle.
- `conv_digits` in, 32: converter digits, packed the same way as `resp_bcd`.

## Operation
- **Reset values:**
  - all outputs 0, except `conv_start_n`=1;
  - state IDLE;
  - round-robin pointer = N-1, so requester 0 has top priority first.
- **FSM states:** IDLE, START, WAIT, RESP.
- **IDLE:**
  - Waits until `req` is non-zero and `conv_ready`=1. While `conv_ready`=0, no grant is made.
  - Winner is the first set bit of `req`, searching upward from pointer+1 with wrap.
  - On a grant: latch the winner ID, latch `conv_value` = that requester's `req_value` slice, go to START.
- **START:**
  - `conv_start_n`=0 for exactly this one cycle. `conv_value` is already stable.
  - Next state WAIT.
- **WAIT:**
  - `conv_start_n`=1.
  - On `conv_done_n`=0: capture `conv_digits` into `resp_bcd`, clear `resp_err`, go to RESP.
- **RESP:**
  - `resp_valid`=1, `ack[winner]`=1, `resp_id`=winner.
  - Pointer updates to the winner.
  - Next state IDLE.
- **Requester rule:** hold `req` and `req_value` stable until `ack`. `req` still high in the cycle after `ack` counts as a new request, served after all other pending requesters.
- `req` dropped before its grant is simply not served. `req_value` is sampled only in the grant cycle; changes after the grant are ignored.
- Simultaneous requests are served strictly by round-robin order; no requester waits more than N-1 other services.
- A `conv_done_n` pulse outside WAIT is ignored.
- **Reset mid-operation:** all state returns to reset values immediately. No `ack` is issued for the interrupted request. The converter shares `rst`.

## Timing
- Request sampled in IDLE at cycle t:
  - `conv_start_n` low at t+1;
  - converter done (its final cycle) at t+54;
  - `resp_valid`/`ack` at t+55;
  - IDLE again at t+56.
- Throughput: one conversion per 56 cycles with back-to-back requests.
- Correctness does not depend on the fixed latency; only `conv_done_n` ends WAIT.

## Configuration
- **`BCD_ARB_TIMEOUT_EN` defined:**
  - A 7-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches 96 without `conv_done_n`: go to RESP with `resp_err`=1 and `resp_bcd`=0.
  - `ack` and `resp_valid` pulse as normal and the pointer advances.
- **`BCD_ARB_TIMEOUT_EN` undefined:**
  - No counter; WAIT lasts until done.
  - `resp_err` is tied to 0.

## Test plan
- **Single conversion:** `req`=4'b0001, value 26'd12345678, converter model attached → `resp_valid` exactly 55 cycles after the request is sampled, `resp_id`=0, `resp_bcd`=32'h12345678, `ack`=4'b0001 for one cycle.
- **Boundary values:** requester 3 value 26'd67108863, then 26'd0 → `resp_bcd`=32'h67108863, then 32'h00000000.
- **Round-robin order:** `req`=4'b1111 held continuously, each requester re-requesting after its ack → `resp_id` sequence 0,1,2,3,0 with one response every 56 cycles; each `ack` pulse matches `resp_id`.
- **Simultaneous requests:** requesters 0 and 2 request together; after 0 is served, 0 re-requests → order 0,2,0.
- **Handshake gating:** `conv_ready` forced 0 while `req`=4'b0100 → `conv_start_n` stays 1 and `busy` stays 0; release `conv_ready` → start pulse on the next cycle.
- **Reset and timeout:**
  - Assert `rst` low during WAIT → next cycle all outputs are at reset values and no `ack` is issued.
  - With `BCD_ARB_TIMEOUT_EN` and a converter stub that holds `conv_done_n`=1 → `resp_err`=1 and `resp_bcd`=0, 97 cycles after WAIT is entered.

Source files
------------

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter
//   Round-robin arbiter that shares one binary-to-BCD converter among N
//   requesters. Each grant launches one conversion through the converter's
//   active-low start/done handshake. The captured 8-digit packed BCD result
//   is returned together with the winner's ID.
//
// Parameters
//   N    number of requesters (2..8)
//   IDW  requester ID width, ceil(log2 N)
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   req           level request, one bit per requester
//   req_value     packed 26-bit operands, requester i at [26i+25:26i]
//   ack           one-cycle pulse to the served requester
//   resp_valid    one-cycle response strobe
//   resp_id       ID of the served requester
//   resp_bcd      digit7..digit0, 4 bits each; holds until the next response
//   resp_err      conversion timed out
//   busy          high whenever the FSM is not in IDLE
//   conv_value    registered operand to the converter
//   conv_start_n  active-low start strobe to the converter
//   conv_ready    converter idle
//   conv_done_n   active-low done from the converter; digits valid same cycle
//   conv_digits   converter result digits
//
// Build option
//   BCD_ARB_TIMEOUT_EN  when defined, WAIT gives up after 96 cycles without
//                       done and returns resp_err=1 with resp_bcd=0.
module bcd_conv_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [N*26-1:0]   req_value,
  output logic [N-1:0]      ack,
  output logic              resp_valid,
  output logic [IDW-1:0]    resp_id,
  output logic [31:0]       resp_bcd,
  output logic              resp_err,
  output logic              busy,
  output logic [25:0]       conv_value,
  output logic              conv_start_n,
  input  logic              conv_ready,
  input  logic              conv_done_n,
  input  logic [31:0]       conv_digits
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [25:0]     r_value;
  logic [31:0]     r_bcd;

  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic [25:0]     w_win_value;
  int unsigned     w_idx;

`ifdef BCD_ARB_TIMEOUT_EN
  logic [6:0]      r_tcnt;
  logic            r_err;
  logic            w_timeout;
  assign w_timeout = (r_tcnt == 7'd96);
`endif

  // Round-robin search: first set request above the last winner, with wrap.
  always_comb begin
    w_found     = 1'b0;
    w_win       = '0;
    w_win_value = '0;
    w_idx       = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = (32'(r_ptr) + k) % N;
      if (!w_found && req[w_idx]) begin
        w_found     = 1'b1;
        w_win       = IDW'(w_idx);
        w_win_value = req_value[w_idx*26 +: 26];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found && conv_ready) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        if (!conv_done_n) w_next = S_RESP;
`ifdef BCD_ARB_TIMEOUT_EN
        else if (w_timeout) w_next = S_RESP;
`endif
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= IDW'(N - 1);
      r_id    <= '0;
      r_value <= '0;
      r_bcd   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_found && conv_ready) begin
            r_id    <= w_win;
            r_value <= w_win_value;
          end
        end
        S_WAIT: begin
          if (!conv_done_n) r_bcd <= conv_digits;
`ifdef BCD_ARB_TIMEOUT_EN
          else if (w_timeout) r_bcd <= '0;
`endif
        end
        S_RESP: r_ptr <= r_id;
        default: ;
      endcase
    end
  end

`ifdef BCD_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_START) r_tcnt <= '0;
      else if (r_state == S_WAIT) r_tcnt <= r_tcnt + 7'd1;

      if (r_state == S_WAIT) begin
        if (!conv_done_n) r_err <= 1'b0;
        else if (w_timeout) r_err <= 1'b1;
      end
    end
  end
  assign resp_err = r_err;
`else
  assign resp_err = 1'b0;
`endif

  // Strobes are decoded from the registered state, so they are clean
  // single-cycle pulses that line up with the state boundaries.
  always_comb begin
    ack = '0;
    if (r_state == S_RESP) ack[r_id] = 1'b1;
  end

  assign resp_valid   = (r_state == S_RESP);
  assign resp_id      = r_id;
  assign resp_bcd     = r_bcd;
  assign busy         = (r_state != S_IDLE);
  assign conv_value   = r_value;
  assign conv_start_n = (r_state != S_START);

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
module tb_bcd_conv_arbiter;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req;
  logic [103:0]  req_value;
  logic [3:0]    ack;
  logic          resp_valid;
  logic [1:0]    resp_id;
  logic [31:0]   resp_bcd;
  logic          resp_err;
  logic          busy;
  logic [25:0]   conv_value;
  logic          conv_start_n;
  logic          conv_ready;
  logic          conv_done_n;
  logic [31:0]   conv_digits;

  logic          ready_en;
  logic          force_done;
  logic          stub_hold;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_conv_arbiter #(.N(4), .IDW(2)) dut (
    .clk          (clk),
    .rst          (rst_n),
    .req          (req),
    .req_value    (req_value),
    .ack          (ack),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_bcd     (resp_bcd),
    .resp_err     (resp_err),
    .busy         (busy),
    .conv_value   (conv_value),
    .conv_start_n (conv_start_n),
    .conv_ready   (conv_ready),
    .conv_done_n  (conv_done_n),
    .conv_digits  (conv_digits)
  );

  // Converter model: start seen at an edge, done during its 53rd busy cycle.
  int unsigned   mc;
  logic [25:0]   m_val;

  function automatic logic [31:0] to_bcd(input logic [25:0] v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = 32'(v);
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc    <= 0;
      m_val <= '0;
    end else if (mc == 0) begin
      if (!conv_start_n) begin
        mc    <= 1;
        m_val <= conv_value;
      end
    end else if (mc == 53) begin
      mc <= 0;
    end else begin
      mc <= mc + 1;
    end
  end

  assign conv_ready  = (mc == 0) && ready_en;
  assign conv_done_n = (!(mc == 53) && !force_done) || stub_hold;
  assign conv_digits = to_bcd(m_val);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!resp_valid && n < 300);
    chk("resp_seen", 64'(resp_valid), 64'd1);
  endtask

  int n;
  logic seen;
  logic [31:0] rr_bcd [4];

  initial begin
    rst_n      = 1'b0;
    req        = '0;
    req_value  = '0;
    ready_en   = 1'b1;
    force_done = 1'b0;
    stub_hold  = 1'b0;
    rr_bcd[0] = 32'h00000011;
    rr_bcd[1] = 32'h00002222;
    rr_bcd[2] = 32'h00333333;
    rr_bcd[3] = 32'h44444444;
    tick();
    tick();

    // Reset state
    chk("rst_ack",     64'(ack),          64'd0);
    chk("rst_valid",   64'(resp_valid),   64'd0);
    chk("rst_id",      64'(resp_id),      64'd0);
    chk("rst_bcd",     64'(resp_bcd),     64'd0);
    chk("rst_err",     64'(resp_err),     64'd0);
    chk("rst_busy",    64'(busy),         64'd0);
    chk("rst_value",   64'(conv_value),   64'd0);
    chk("rst_start_n", 64'(conv_start_n), 64'd1);
    rst_n = 1'b1;
    tick();

    // Stray done outside WAIT is ignored
    force_done = 1'b1;
    tick();
    chk("stray_done_valid", 64'(resp_valid), 64'd0);
    chk("stray_done_busy",  64'(busy),       64'd0);
    force_done = 1'b0;
    tick();

    // Single conversion: response 55 cycles after the request is sampled
    req_value[25:0] = 26'd12345678;
    req = 4'b0001;
    tick();
    chk("single_start_n", 64'(conv_start_n), 64'd0);
    chk("single_value",   64'(conv_value),   64'd12345678);
    chk("single_busy",    64'(busy),         64'd1);
    tick();
    chk("single_start_1cyc", 64'(conv_start_n), 64'd1);
    wait_resp(n);
    chk("single_latency", 64'(n + 2), 64'd55);
    chk("single_id",  64'(resp_id),  64'd0);
    chk("single_bcd", 64'(resp_bcd), 64'h12345678);
    chk("single_ack", 64'(ack),      64'b0001);
    chk("single_err", 64'(resp_err), 64'd0);
    req = '0;
    tick();
    chk("single_ack_pulse", 64'(ack),        64'd0);
    chk("single_valid_end", 64'(resp_valid), 64'd0);
    chk("single_idle",      64'(busy),       64'd0);
    chk("single_bcd_hold",  64'(resp_bcd),   64'h12345678);

    // Boundary values on requester 3
    req_value[3*26 +: 26] = 26'd67108863;
    req = 4'b1000;
    wait_resp(n);
    chk("max_latency", 64'(n), 64'd55);
    chk("max_id",  64'(resp_id),  64'd3);
    chk("max_bcd", 64'(resp_bcd), 64'h67108863);
    chk("max_ack", 64'(ack),      64'b1000);
    req_value[3*26 +: 26] = 26'd0;
    wait_resp(n);
    chk("zero_period", 64'(n), 64'd56);
    chk("zero_id",  64'(resp_id),  64'd3);
    chk("zero_bcd", 64'(resp_bcd), 64'h00000000);
    req = '0;
    tick();

    // Simultaneous 0 and 2, requester 0 re-requests: 0,2,0
    req_value[2*26 +: 26] = 26'd333333;
    req = 4'b0101;
    wait_resp(n);
    chk("sim_id0", 64'(resp_id), 64'd0);
    chk("sim_ack0", 64'(ack), 64'b0001);
    wait_resp(n);
    chk("sim_id1",  64'(resp_id),  64'd2);
    chk("sim_ack1", 64'(ack),      64'b0100);
    chk("sim_bcd1", 64'(resp_bcd), 64'h00333333);
    req = 4'b0001;
    wait_resp(n);
    chk("sim_id2", 64'(resp_id), 64'd0);
    chk("sim_bcd2", 64'(resp_bcd), 64'h12345678);
    req = '0;
    tick();

    // Reset during WAIT
    req_value[1*26 +: 26] = 26'd2222;
    req = 4'b0010;
    repeat (10) tick();
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",    64'(busy),         64'd0);
    chk("mid_rst_start_n", 64'(conv_start_n), 64'd1);
    chk("mid_rst_bcd",     64'(resp_bcd),     64'd0);
    chk("mid_rst_value",   64'(conv_value),   64'd0);
    tick();
    chk("mid_rst_ack",   64'(ack),        64'd0);
    chk("mid_rst_valid", 64'(resp_valid), 64'd0);
    req = '0;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      tick();
      if (resp_valid || ack != 4'b0000) seen = 1'b1;
    end
    chk("mid_rst_no_ack", 64'(seen), 64'd0);

    // Round-robin with all four requesting continuously
    req_value[0*26 +: 26] = 26'd11;
    req_value[1*26 +: 26] = 26'd2222;
    req_value[2*26 +: 26] = 26'd333333;
    req_value[3*26 +: 26] = 26'd44444444;
    req = 4'b1111;
    wait_resp(n);
    chk("rr_first_latency", 64'(n), 64'd55);
    chk("rr_id_0",  64'(resp_id),  64'd0);
    chk("rr_ack_0", 64'(ack),      64'b0001);
    chk("rr_bcd_0", 64'(resp_bcd), 64'(rr_bcd[0]));
    for (int k = 1; k <= 4; k++) begin
      wait_resp(n);
      chk("rr_period", 64'(n),        64'd56);
      chk("rr_id",     64'(resp_id),  64'(k % 4));
      chk("rr_ack",    64'(ack),      64'(4'b0001 << (k % 4)));
      chk("rr_bcd",    64'(resp_bcd), 64'(rr_bcd[k % 4]));
    end
    req = '0;
    tick();

    // conv_ready gating
    ready_en = 1'b0;
    req = 4'b0100;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (!conv_start_n || busy) seen = 1'b1;
    end
    chk("gate_held", 64'(seen), 64'd0);
    ready_en = 1'b1;
    tick();
    chk("gate_start_n", 64'(conv_start_n), 64'd0);
    wait_resp(n);
    chk("gate_latency", 64'(n), 64'd54);
    chk("gate_id",  64'(resp_id),  64'd2);
    chk("gate_bcd", 64'(resp_bcd), 64'h00333333);
    req = '0;
    tick();

`ifdef BCD_ARB_TIMEOUT_EN
    // Converter that never completes
    stub_hold = 1'b1;
    req = 4'b0001;
    tick();
    tick();
    wait_resp(n);
    chk("to_latency", 64'(n),        64'd97);
    chk("to_err",     64'(resp_err), 64'd1);
    chk("to_bcd",     64'(resp_bcd), 64'd0);
    chk("to_ack",     64'(ack),      64'b0001);
    req = '0;
    stub_hold = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
